param_stack: RTL and testbench
==============================

PARAM_STACK -- requirements
Module: param_stack

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning the data word width in bits (>=1).
REQ-002 The block SHALL have parameter DEPTH, default 16, meaning the maximum number of stored entries (power of two, >=2).
REQ-003 The block SHALL have port i_clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port i_reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port i_push, input, 1 bit: push request.
REQ-006 The block SHALL have port i_pop, input, 1 bit: pop request.
REQ-007 The block SHALL have port i_data, input, WIDTH bits: the word to push or replace with.
REQ-008 The block SHALL have port i_clr_err, input, 1 bit: clears the sticky error flags.
REQ-009 The block SHALL have port o_top, output, WIDTH bits: the top-of-stack word.
REQ-010 The block SHALL have port o_next, output, WIDTH bits: the second-from-top word.
REQ-011 The block SHALL have port o_count, output, clog2(DEPTH)+1 bits: the current number of entries.
REQ-012 The block SHALL have ports o_empty and o_full, output, 1 bit each: count==0 and count==DEPTH.
REQ-013 The block SHALL have ports o_overflow and o_underflow, output, 1 bit each: sticky error flags.

Function
REQ-014 Operation decode SHALL be: push only = PUSH; pop only = POP; both = REPLACE; neither = NOP.
REQ-015 PUSH on a stack that is not full SHALL store i_data as the new top and increment count, visible on o_top/o_count the cycle after the edge.
REQ-016 POP on a non-empty stack SHALL decrement count, and the former second entry SHALL appear on o_top the next cycle.
REQ-017 REPLACE on a non-empty stack SHALL overwrite the top with i_data and leave count unchanged.
REQ-018 REPLACE on an empty stack SHALL behave as PUSH, raising no error.
REQ-019 PUSH when full SHALL leave all contents and count unchanged and set o_overflow.
REQ-020 POP when empty SHALL leave state unchanged and set o_underflow.
REQ-021 o_top SHALL be 0 when empty, and o_next SHALL be 0 when count<2.
REQ-022 The top entry SHALL be held in a dedicated register so that o_top and o_next are register/array outputs with no combinational path from i_push, i_pop or i_data.
REQ-023 i_clr_err SHALL clear both error flags at the next edge; if an error occurs in the same cycle, the set SHALL win.
REQ-024 Count SHALL never wrap; the full sequence 0..DEPTH SHALL be representable.

Reset
REQ-025 While i_reset is high at an edge, count, o_top, o_overflow and o_underflow SHALL become 0, and reset SHALL override any simultaneous operation.
REQ-026 Array contents SHALL NOT require reset; stale entries SHALL never be observable through any output.

Configuration
REQ-027 With macro PARAM_STACK_PEEK_EN defined, the block SHALL add input i_peek_idx (clog2(DEPTH) bits) and output o_peek (WIDTH bits), a combinational read of the entry i_peek_idx positions below the top (0 = top), returning 0 when i_peek_idx >= count.
REQ-028 Without PARAM_STACK_PEEK_EN, those ports and their read logic SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-029 A shared package param_stack_pkg SHALL hold the operation enum (NOP, PUSH, POP, REPLACE) and the count-width helper function.
REQ-030 A single sub-module stack_ptr SHALL implement the saturating count/pointer with inc/dec/hold control and the full/empty flags.

Verification
REQ-031 The bench SHALL cover: reset, then push 0x1111, 0x2222, 0x3333 -> o_top=0x3333, o_next=0x2222, o_count=3.
REQ-032 The bench SHALL cover: DEPTH=16, push 17 times -> o_full=1, o_count=16, o_overflow=1, o_top equal to the 16th value.
REQ-033 The bench SHALL cover: pop on an empty stack -> o_underflow=1, o_count=0, o_top=0; then i_clr_err -> flag 0 the next cycle.
REQ-034 The bench SHALL cover: stack [0xAAAA, 0xBBBB], push+pop with 0xCCCC -> o_top=0xCCCC, o_next=0xAAAA, o_count=2.
REQ-035 The bench SHALL cover: i_reset asserted together with push while count=5 -> o_count=0, o_empty=1 next cycle.
REQ-036 The bench SHALL cover, with PARAM_STACK_PEEK_EN defined: stack [1,2,3] (top 3), i_peek_idx=2 -> o_peek=1; i_peek_idx=3 -> o_peek=0.

Source files
------------

// File: rtl/param_stack_pkg.sv
// Shared types and helpers for the parameterised LIFO stack.
// The optional peek port is enabled with macro PARAM_STACK_PEEK_EN.
package param_stack_pkg;

    // Encoding is {pop, push}, so the decode is a direct cast of those two bits.
    typedef enum logic [1:0] {
        OP_NOP     = 2'b00,
        OP_PUSH    = 2'b01,
        OP_POP     = 2'b10,
        OP_REPLACE = 2'b11
    } op_e;

    // The count runs 0..DEPTH inclusive, so it needs one bit more than an index.
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/stack_ptr.sv
// Saturating occupancy counter for the stack, with full/empty flags.
// Increment is ignored when full and decrement is ignored when empty.
module stack_ptr
    import param_stack_pkg::*;
#(
    parameter  int DEPTH = 16,
    localparam int CW    = count_width(DEPTH)
) (
    input  logic          i_clock,
    input  logic          i_reset,
    input  logic          i_inc,
    input  logic          i_dec,
    output logic [CW-1:0] o_count,
    output logic          o_empty,
    output logic          o_full
);

    logic [CW-1:0] r_count;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_count <= '0;
        end else if (i_inc && !i_dec && !o_full) begin
            r_count <= r_count + CW'(1);
        end else if (i_dec && !i_inc && !o_empty) begin
            r_count <= r_count - CW'(1);
        end
    end

    assign o_count = r_count;
    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CW'(DEPTH));

endmodule

// File: rtl/param_stack.sv
// LIFO stack with a dedicated top-of-stack register and sticky error flags.
// Define PARAM_STACK_PEEK_EN to add the i_peek_idx/o_peek random-read port.
module param_stack
    import param_stack_pkg::*;
#(
    parameter  int WIDTH = 16,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = count_width(DEPTH)
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_clr_err,
    output logic [WIDTH-1:0] o_top,
    output logic [WIDTH-1:0] o_next,
    output logic [CW-1:0]    o_count,
    output logic             o_empty,
    output logic             o_full,
    output logic             o_overflow,
    output logic             o_underflow
`ifdef PARAM_STACK_PEEK_EN
    ,
    input  logic [AW-1:0]    i_peek_idx,
    output logic [WIDTH-1:0] o_peek
`endif
);

    // r_mem holds the entries beneath the top; slot count-2 is the second entry.
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_top;
    logic             r_overflow;
    logic             r_underflow;

    op_e              w_op;
    logic             w_inc;
    logic             w_dec;
    logic             w_wr_top;
    logic             w_spill;
    logic             w_ovf_set;
    logic             w_unf_set;
    logic [CW-1:0]    w_count;
    logic             w_empty;
    logic             w_full;
    logic [AW-1:0]    w_wr_idx;
    logic [AW-1:0]    w_nx_idx;
    logic [WIDTH-1:0] w_next;

    stack_ptr #(
        .DEPTH (DEPTH)
    ) u_stack_ptr (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_inc   (w_inc),
        .i_dec   (w_dec),
        .o_count (w_count),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

    always_comb begin
        w_op      = op_e'({i_pop, i_push});
        w_inc     = 1'b0;
        w_dec     = 1'b0;
        w_wr_top  = 1'b0;
        w_spill   = 1'b0;
        w_ovf_set = 1'b0;
        w_unf_set = 1'b0;
        case (w_op)
            OP_PUSH: begin
                if (w_full) begin
                    w_ovf_set = 1'b1;
                end else begin
                    w_inc    = 1'b1;
                    w_wr_top = 1'b1;
                    w_spill  = !w_empty;
                end
            end
            OP_POP: begin
                if (w_empty) begin
                    w_unf_set = 1'b1;
                end else begin
                    w_dec = 1'b1;
                end
            end
            OP_REPLACE: begin
                // An empty stack has no top to overwrite, so this degrades to a push.
                w_wr_top = 1'b1;
                w_inc    = w_empty;
            end
            default: ;
        endcase
    end

    // Modulo-2^AW arithmetic on the low count bits is exact for count in 1..DEPTH.
    assign w_wr_idx = w_count[AW-1:0] - AW'(1);
    assign w_nx_idx = w_count[AW-1:0] - AW'(2);
    assign w_next   = (w_count >= CW'(2)) ? r_mem[w_nx_idx] : '0;

    always_ff @(posedge i_clock) begin
        if (w_spill && !i_reset) begin
            r_mem[w_wr_idx] <= r_top;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_top       <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_top) begin
                r_top <= i_data;
            end else if (w_dec) begin
                r_top <= w_next;
            end
            r_overflow  <= w_ovf_set | (r_overflow  & ~i_clr_err);
            r_underflow <= w_unf_set | (r_underflow & ~i_clr_err);
        end
    end

    assign o_top       = r_top;
    assign o_next      = w_next;
    assign o_count     = w_count;
    assign o_empty     = w_empty;
    assign o_full      = w_full;
    assign o_overflow  = r_overflow;
    assign o_underflow = r_underflow;

`ifdef PARAM_STACK_PEEK_EN
    logic [AW-1:0] w_peek_slot;

    assign w_peek_slot = w_count[AW-1:0] - AW'(1) - i_peek_idx;
    assign o_peek = ({1'b0, i_peek_idx} >= w_count) ? '0 :
                    (i_peek_idx == '0)              ? r_top :
                                                      r_mem[w_peek_slot];
`else
    // Without the peek port the array is only read at the second-entry slot.
`endif

endmodule

// File: tb/tb_param_stack.sv
// Scoreboard bench for param_stack (DEPTH=16, WIDTH=16): stimulus queues
// expectations, a monitor compares one cycle after each driven edge.
module tb_param_stack;

    logic        clk;
    logic        i_reset;
    logic        i_push;
    logic        i_pop;
    logic [15:0] i_data;
    logic        i_clr_err;
    logic [15:0] o_top;
    logic [15:0] o_next;
    logic [4:0]  o_count;
    logic        o_empty;
    logic        o_full;
    logic        o_overflow;
    logic        o_underflow;
`ifdef PARAM_STACK_PEEK_EN
    logic [3:0]  i_peek_idx;
    logic [15:0] o_peek;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [15:0] top;
        logic [15:0] nxt;
        logic [4:0]  cnt;
        logic        emp;
        logic        ful;
        logic        ovf;
        logic        unf;
    } exp_t;

    exp_t sb_q[$];

    param_stack #(
        .WIDTH (16),
        .DEPTH (16)
    ) dut (
        .i_clock     (clk),
        .i_reset     (i_reset),
        .i_push      (i_push),
        .i_pop       (i_pop),
        .i_data      (i_data),
        .i_clr_err   (i_clr_err),
        .o_top       (o_top),
        .o_next      (o_next),
        .o_count     (o_count),
        .o_empty     (o_empty),
        .o_full      (o_full),
        .o_overflow  (o_overflow),
        .o_underflow (o_underflow)
`ifdef PARAM_STACK_PEEK_EN
        ,
        .i_peek_idx  (i_peek_idx),
        .o_peek      (o_peek)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one operation for the next rising edge and queue the state expected after it.
    task automatic step(input logic p, input logic q, input logic [15:0] d,
                        input logic c, input logic r, input string nm,
                        input logic [15:0] et, input logic [15:0] en,
                        input int ec, input logic eo, input logic eu);
        exp_t e;
        @(negedge clk);
        i_push    = p;
        i_pop     = q;
        i_data    = d;
        i_clr_err = c;
        i_reset   = r;
        e.name = nm;
        e.top  = et;
        e.nxt  = en;
        e.cnt  = 5'(ec);
        e.emp  = (ec == 0);
        e.ful  = (ec == 16);
        e.ovf  = eo;
        e.unf  = eu;
        sb_q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                checks++;
                if (o_top !== e.top || o_next !== e.nxt || o_count !== e.cnt ||
                    o_empty !== e.emp || o_full !== e.ful ||
                    o_overflow !== e.ovf || o_underflow !== e.unf) begin
                    errors++;
                    $display("FAIL %s: got top=%h next=%h cnt=%0d e=%b f=%b ovf=%b unf=%b; want top=%h next=%h cnt=%0d e=%b f=%b ovf=%b unf=%b",
                             e.name, o_top, o_next, o_count, o_empty, o_full, o_overflow, o_underflow,
                             e.top, e.nxt, e.cnt, e.emp, e.ful, e.ovf, e.unf);
                end else begin
                    $display("ok   %s: top=%h next=%h cnt=%0d e=%b f=%b ovf=%b unf=%b",
                             e.name, o_top, o_next, o_count, o_empty, o_full, o_overflow, o_underflow);
                end
            end
        end
    end

`ifdef PARAM_STACK_PEEK_EN
    task automatic peek_check(input logic [3:0] idx, input logic [15:0] want, input string nm);
        @(negedge clk);
        i_push     = 1'b0;
        i_pop      = 1'b0;
        i_clr_err  = 1'b0;
        i_reset    = 1'b0;
        i_peek_idx = idx;
        #1;
        checks++;
        if (o_peek !== want) begin
            errors++;
            $display("FAIL %s: got o_peek=%h want %h", nm, o_peek, want);
        end else begin
            $display("ok   %s: o_peek=%h", nm, o_peek);
        end
    endtask
`endif

    initial begin : stimulus
        i_reset   = 1'b1;
        i_push    = 1'b0;
        i_pop     = 1'b0;
        i_data    = '0;
        i_clr_err = 1'b0;
`ifdef PARAM_STACK_PEEK_EN
        i_peek_idx = '0;
`endif
        //        p  q  data       c  r  name          top        next       cnt ovf unf
        step(0, 0, 16'h0000, 0, 1, "reset0",      16'h0000, 16'h0000, 0, 0, 0);
        step(0, 0, 16'h0000, 0, 1, "reset1",      16'h0000, 16'h0000, 0, 0, 0);
        step(1, 0, 16'h1111, 0, 0, "push1111",    16'h1111, 16'h0000, 1, 0, 0);
        step(1, 0, 16'h2222, 0, 0, "push2222",    16'h2222, 16'h1111, 2, 0, 0);
        step(1, 0, 16'h3333, 0, 0, "push3333",    16'h3333, 16'h2222, 3, 0, 0);
        step(0, 1, 16'h0000, 0, 0, "pop_a",       16'h2222, 16'h1111, 2, 0, 0);
        step(0, 1, 16'h0000, 0, 0, "pop_b",       16'h1111, 16'h0000, 1, 0, 0);
        step(0, 1, 16'h0000, 0, 0, "pop_c",       16'h0000, 16'h0000, 0, 0, 0);
        step(0, 1, 16'h0000, 0, 0, "pop_empty",   16'h0000, 16'h0000, 0, 0, 1);
        step(0, 0, 16'h0000, 0, 0, "unf_sticky",  16'h0000, 16'h0000, 0, 0, 1);
        step(0, 0, 16'h0000, 1, 0, "clr_unf",     16'h0000, 16'h0000, 0, 0, 0);
        step(1, 1, 16'hAAAA, 0, 0, "repl_empty",  16'hAAAA, 16'h0000, 1, 0, 0);
        step(1, 0, 16'hBBBB, 0, 0, "pushBBBB",    16'hBBBB, 16'hAAAA, 2, 0, 0);
        step(1, 1, 16'hCCCC, 0, 0, "replCCCC",    16'hCCCC, 16'hAAAA, 2, 0, 0);
        step(0, 0, 16'h0000, 0, 1, "reset2",      16'h0000, 16'h0000, 0, 0, 0);

        for (int i = 0; i < 17; i++) begin
            step(1, 0, 16'(16'h5000 + i), 0, 0, "fill",
                 (i < 16) ? 16'(16'h5000 + i) : 16'h500F,
                 (i == 0) ? 16'h0000 : ((i < 16) ? 16'(16'h5000 + i - 1) : 16'h500E),
                 (i < 16) ? i + 1 : 16,
                 (i == 16), 1'b0);
        end
        for (int c = 15; c >= 0; c--) begin
            step(0, 1, 16'h0000, 0, 0, "drain",
                 (c > 0)  ? 16'(16'h5000 + c - 1) : 16'h0000,
                 (c >= 2) ? 16'(16'h5000 + c - 2) : 16'h0000,
                 c, 1'b1, 1'b0);
        end
        step(0, 1, 16'h0000, 0, 0, "pop_empty2",  16'h0000, 16'h0000, 0, 1, 1);
        step(0, 1, 16'h0000, 1, 0, "clr_vs_set",  16'h0000, 16'h0000, 0, 0, 1);
        step(0, 0, 16'h0000, 1, 0, "clr_both",    16'h0000, 16'h0000, 0, 0, 0);

        for (int k = 1; k <= 5; k++) begin
            step(1, 0, 16'(16'h7000 + k), 0, 0, "push5",
                 16'(16'h7000 + k),
                 (k > 1) ? 16'(16'h7000 + k - 1) : 16'h0000,
                 k, 1'b0, 1'b0);
        end
        step(1, 0, 16'h9999, 0, 1, "rst_push",    16'h0000, 16'h0000, 0, 0, 0);
        step(0, 0, 16'h0000, 0, 0, "post_rst",    16'h0000, 16'h0000, 0, 0, 0);

`ifdef PARAM_STACK_PEEK_EN
        step(1, 0, 16'h0001, 0, 0, "push1",       16'h0001, 16'h0000, 1, 0, 0);
        step(1, 0, 16'h0002, 0, 0, "push2",       16'h0002, 16'h0001, 2, 0, 0);
        step(1, 0, 16'h0003, 0, 0, "push3",       16'h0003, 16'h0002, 3, 0, 0);
        peek_check(4'd2, 16'h0001, "peek2");
        peek_check(4'd3, 16'h0000, "peek3");
        peek_check(4'd0, 16'h0003, "peek0");
        peek_check(4'd1, 16'h0002, "peek1");
`endif

        @(negedge clk);
        i_push    = 1'b0;
        i_pop     = 1'b0;
        i_clr_err = 1'b0;
        i_reset   = 1'b0;
        @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain_queue: got %0d pending want 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
